// File: rtl/controle_posicionamento_frota_pkg.sv
// Shared types, constants and helpers for the fleet placement sequencer.
// BLINK_CYCLES is only consumed when the BLINK_EN build option is defined.
package frota_pkg;

    localparam int N_NAVIOS     = 5;
    localparam int COORD_W      = 4;
    localparam int NUM_CELLS    = 7;
    localparam int X_OFF        = 6;
    localparam int Y_OFF        = 10;
    localparam int STRIDE       = 8;
    localparam int BLINK_CYCLES = 12_500_000;

    localparam logic [2:0] LEN [N_NAVIOS] = '{3'd2, 3'd3, 3'd3, 3'd4, 3'd5};

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        CHECK,
        COMMIT,
        DONE
    } estado_t;

    function automatic logic [2:0] len_navio(input logic [2:0] idx);
        logic [2:0] r;
        r = LEN[0];
        for (int i = 0; i < N_NAVIOS; i++) begin
            if (idx == 3'(i)) r = LEN[i];
        end
        return r;
    endfunction

    // Only meaningful for in-bounds coordinates (1..8 on both axes).
    function automatic logic [5:0] indice_ocupacao(input logic [3:0] x, input logic [3:0] y);
        return 6'(STRIDE * (int'(y) - 1) + (int'(x) - 1));
    endfunction

endpackage

// File: rtl/controle_posicionamento_frota_if.sv
// Button inputs and renderer-facing outputs of the placement sequencer.
interface controle_posicionamento_frota_if;

    logic        iniciar;
    logic        btn_cima;
    logic        btn_baixo;
    logic        btn_esq;
    logic        btn_dir;
    logic        btn_girar;
    logic        btn_confirma;
    logic [63:0] posicoes0;
    logic [63:0] posicoes1;
    logic [63:0] posicoes2;
    logic [63:0] posicoes3;
    logic [63:0] posicoes4;
    logic [63:0] posicoes_preview;
    logic        preview_visivel;
    logic [2:0]  navio_atual;
    logic        aceita;
    logic        rejeita;
    logic        concluido;

    modport master (
        output iniciar, btn_cima, btn_baixo, btn_esq, btn_dir, btn_girar, btn_confirma,
        input  posicoes0, posicoes1, posicoes2, posicoes3, posicoes4,
        input  posicoes_preview, preview_visivel, navio_atual, aceita, rejeita, concluido
    );

    modport slave (
        input  iniciar, btn_cima, btn_baixo, btn_esq, btn_dir, btn_girar, btn_confirma,
        output posicoes0, posicoes1, posicoes2, posicoes3, posicoes4,
        output posicoes_preview, preview_visivel, navio_atual, aceita, rejeita, concluido
    );

endinterface

// File: rtl/controle_posicionamento_frota_calc_celula.sv
// Combinational cell k of a ship anchored at (cx,cy), plus its in-bounds flag.
module calc_celula
    import frota_pkg::*;
(
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic               vertical_i,
    input  logic [2:0]         k_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               dentro_o
);

    logic [COORD_W-1:0] passo;

    // Anchor max 8 plus k max 6 fits in 4 bits, so no wrap can fake an in-bounds cell.
    assign passo    = {1'b0, k_i};
    assign x_o      = vertical_i ? cx_i : cx_i + passo;
    assign y_o      = vertical_i ? cy_i + passo : cy_i;
    assign dentro_o = (x_o <= 4'd8) && (y_o <= 4'd8);

endmodule

// File: rtl/controle_posicionamento_frota.sv
// Fleet placement sequencer: moves/rotates a ship anchor, checks cells one per cycle, commits.
// Optional build macro BLINK_EN makes the preview blink while the player is moving the ship.
module controle_posicionamento_frota
    import frota_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    controle_posicionamento_frota_if.slave bus
);

    estado_t            estado_q, estado_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               vert_q, vert_d;
    logic [2:0]         k_q, k_d;
    logic [2:0]         navio_q, navio_d;
    logic [63:0]        ocup_q, ocup_d;
    logic [63:0]        pos_q [N_NAVIOS];
    logic [63:0]        pos_d [N_NAVIOS];
    logic               aceita_q, aceita_d;

    logic [2:0]         len_atual;
    logic [63:0]        candidato;
    logic [63:0]        mascara;
    logic [COORD_W-1:0] cel_x [NUM_CELLS];
    logic [COORD_W-1:0] cel_y [NUM_CELLS];
    logic               cel_dentro [NUM_CELLS];
    logic [COORD_W-1:0] chk_x, chk_y;
    logic               chk_dentro, chk_ok, ultimo;
    logic               mostra;

    assign len_atual = len_navio(navio_q);

    generate
        for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cel
            calc_celula u_cel (
                .cx_i      (cx_q),
                .cy_i      (cy_q),
                .vertical_i(vert_q),
                .k_i       (3'(g)),
                .x_o       (cel_x[g]),
                .y_o       (cel_y[g]),
                .dentro_o  (cel_dentro[g])
            );
        end
    endgenerate

    calc_celula u_chk (
        .cx_i      (cx_q),
        .cy_i      (cy_q),
        .vertical_i(vert_q),
        .k_i       (k_q),
        .x_o       (chk_x),
        .y_o       (chk_y),
        .dentro_o  (chk_dentro)
    );

    assign chk_ok = chk_dentro && !ocup_q[indice_ocupacao(chk_x, chk_y)];
    assign ultimo = (k_q == len_atual - 3'd1);

    // The mask is only consumed at commit, when every cell has already passed the check.
    always_comb begin
        candidato = '0;
        mascara   = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (k < int'(len_atual) && cel_dentro[k]) begin
                candidato[X_OFF + STRIDE*k -: COORD_W] = cel_x[k];
                candidato[Y_OFF + STRIDE*k -: COORD_W] = cel_y[k];
                mascara[indice_ocupacao(cel_x[k], cel_y[k])] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) estado_q <= IDLE;
        else          estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE, DONE: if (bus.iniciar) estado_d = PLACE;
            PLACE:      if (bus.btn_confirma) estado_d = CHECK;
            CHECK: begin
                if (!chk_ok)     estado_d = PLACE;
                else if (ultimo) estado_d = COMMIT;
            end
            COMMIT:     estado_d = (navio_q == 3'(N_NAVIOS - 1)) ? DONE : PLACE;
            default:    estado_d = IDLE;
        endcase
    end

    always_comb begin
        cx_d     = cx_q;
        cy_d     = cy_q;
        vert_d   = vert_q;
        k_d      = k_q;
        navio_d  = navio_q;
        ocup_d   = ocup_q;
        pos_d    = pos_q;
        aceita_d = (estado_q == COMMIT);
        case (estado_q)
            IDLE, DONE: begin
                if (bus.iniciar) begin
                    cx_d    = 4'd1;
                    cy_d    = 4'd1;
                    vert_d  = 1'b0;
                    navio_d = 3'd0;
                    ocup_d  = '0;
                    for (int i = 0; i < N_NAVIOS; i++) pos_d[i] = '0;
                end
            end
            PLACE: begin
                if (bus.btn_confirma) begin
                    k_d = 3'd0;
                end else begin
                    if (bus.btn_dir && !bus.btn_esq && cx_q != 4'd8)     cx_d = cx_q + 4'd1;
                    if (bus.btn_esq && !bus.btn_dir && cx_q != 4'd1)     cx_d = cx_q - 4'd1;
                    if (bus.btn_cima && !bus.btn_baixo && cy_q != 4'd8)  cy_d = cy_q + 4'd1;
                    if (bus.btn_baixo && !bus.btn_cima && cy_q != 4'd1)  cy_d = cy_q - 4'd1;
                    if (bus.btn_girar)                                   vert_d = !vert_q;
                end
            end
            CHECK: k_d = k_q + 3'd1;
            COMMIT: begin
                ocup_d = ocup_q | mascara;
                for (int i = 0; i < N_NAVIOS; i++) begin
                    if (navio_q == 3'(i)) pos_d[i] = candidato;
                end
                if (navio_q != 3'(N_NAVIOS - 1)) begin
                    navio_d = navio_q + 3'd1;
                    cx_d    = 4'd1;
                    cy_d    = 4'd1;
                    vert_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx_q     <= 4'd1;
            cy_q     <= 4'd1;
            vert_q   <= 1'b0;
            k_q      <= 3'd0;
            navio_q  <= 3'd0;
            ocup_q   <= '0;
            aceita_q <= 1'b0;
            for (int i = 0; i < N_NAVIOS; i++) pos_q[i] <= '0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            vert_q   <= vert_d;
            k_q      <= k_d;
            navio_q  <= navio_d;
            ocup_q   <= ocup_d;
            aceita_q <= aceita_d;
            for (int i = 0; i < N_NAVIOS; i++) pos_q[i] <= pos_d[i];
        end
    end

`ifdef BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_vis_q, blink_vis_d;

    // Held at "visible, count 0" outside PLACE so every entry starts a fresh half-period.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        if (estado_q != PLACE || cx_d != cx_q || cy_d != cy_q) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_vis_d = !blink_vis_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end

    assign mostra = (estado_q == CHECK) || (estado_q == PLACE && blink_vis_q);
`else
    assign mostra = (estado_q == CHECK) || (estado_q == PLACE);
`endif

    always_comb begin
        bus.rejeita          = (estado_q == CHECK) && !chk_ok;
        bus.concluido        = (estado_q == DONE);
        bus.preview_visivel  = mostra;
        bus.posicoes_preview = (estado_q == CHECK || estado_q == PLACE) ? candidato : 64'd0;
    end

    assign bus.aceita      = aceita_q;
    assign bus.navio_atual = navio_q;
    assign bus.posicoes0   = pos_q[0];
    assign bus.posicoes1   = pos_q[1];
    assign bus.posicoes2   = pos_q[2];
    assign bus.posicoes3   = pos_q[3];
    assign bus.posicoes4   = pos_q[4];

endmodule

// File: tb/tb_controle_posicionamento_frota.sv
// Directed bench for the fleet placement sequencer with a board-level reference model.
module tb_controle_posicionamento_frota;

    localparam logic [6:0] B_INI   = 7'h01;
    localparam logic [6:0] B_UP    = 7'h02;
    localparam logic [6:0] B_DOWN  = 7'h04;
    localparam logic [6:0] B_LEFT  = 7'h08;
    localparam logic [6:0] B_RIGHT = 7'h10;
    localparam logic [6:0] B_ROT   = 7'h20;
    localparam logic [6:0] B_OK    = 7'h40;

    logic clk;
    logic reset_n;
    bit   cmpEn;
    int   total;
    int   bad;
    int   lat;

    controle_posicionamento_frota_if bus ();

    controle_posicionamento_frota dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a board of occupied squares plus the outcome of the pending check.
    int          lens [5] = '{2, 3, 3, 4, 5};
    int          mPhase;
    int          mCx, mCy, mShip, mAge, mFail, mCount;
    bit          mVert, mBusy, mAceita, show;
    bit          mBoard [9][9];
    logic [63:0] mPos [5];

    function automatic logic [63:0] buildVec(input int cx, input int cy, input bit v, input int len);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < len; k++) begin
            int x, y;
            x = v ? cx : cx + k;
            y = v ? cy + k : cy;
            if (x <= 8 && y <= 8) begin
                r[6 + 8*k -: 4] = x[3:0];
                r[10 + 8*k -: 4] = y[3:0];
            end
        end
        return r;
    endfunction

    function automatic int countCells(input logic [63:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 7; k++) if (v[6 + 8*k -: 4] != 4'd0) n++;
        return n;
    endfunction

    task automatic clearBoard();
        for (int x = 0; x < 9; x++) for (int y = 0; y < 9; y++) mBoard[x][y] = 1'b0;
        for (int i = 0; i < 5; i++) mPos[i] = '0;
        mCount = 0;
    endtask

    task automatic modelReset();
        clearBoard();
        mPhase = 0; mCx = 1; mCy = 1; mVert = 1'b0; mShip = 0;
        mBusy = 1'b0; mAge = 0; mFail = -1; mAceita = 1'b0;
    endtask

    task automatic startCheck();
        mFail = -1;
        for (int k = 0; k < lens[mShip]; k++) begin
            int x, y;
            x = mVert ? mCx : mCx + k;
            y = mVert ? mCy + k : mCy;
            if (mFail < 0 && (x > 8 || y > 8 || mBoard[x][y])) mFail = k;
        end
        mBusy = 1'b1;
        mAge  = 0;
    endtask

    task automatic commitModel();
        for (int k = 0; k < lens[mShip]; k++) begin
            if (mVert) mBoard[mCx][mCy + k] = 1'b1;
            else       mBoard[mCx + k][mCy] = 1'b1;
        end
        mPos[mShip] = buildVec(mCx, mCy, mVert, lens[mShip]);
        mCount += lens[mShip];
        mAceita = 1'b1;
        mBusy   = 1'b0;
        if (mShip == 4) mPhase = 2;
        else begin
            mShip++; mCx = 1; mCy = 1; mVert = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else begin
            mAceita = 1'b0;
            if (mBusy) begin
                mAge++;
                if (mFail >= 0 && mAge == mFail + 1)          mBusy = 1'b0;
                else if (mFail < 0 && mAge == lens[mShip] + 1) commitModel();
            end else if (mPhase == 1) begin
                if (bus.btn_confirma) startCheck();
                else begin
                    if (bus.btn_dir && !bus.btn_esq)    mCx = (mCx < 8) ? mCx + 1 : 8;
                    if (bus.btn_esq && !bus.btn_dir)    mCx = (mCx > 1) ? mCx - 1 : 1;
                    if (bus.btn_cima && !bus.btn_baixo) mCy = (mCy < 8) ? mCy + 1 : 8;
                    if (bus.btn_baixo && !bus.btn_cima) mCy = (mCy > 1) ? mCy - 1 : 1;
                    if (bus.btn_girar)                  mVert = !mVert;
                end
            end else if (bus.iniciar) begin
                clearBoard();
                mCx = 1; mCy = 1; mVert = 1'b0; mShip = 0; mPhase = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (cmpEn) begin
            show = (mPhase == 1) && (!mBusy || mAge < lens[mShip]);
            checkOutput("preview", bus.posicoes_preview,
                        show ? buildVec(mCx, mCy, mVert, lens[mShip]) : 64'd0);
            checkOutput("preview_visivel", bus.preview_visivel, show);
            checkOutput("rejeita", bus.rejeita, mBusy && mFail >= 0 && mAge == mFail);
            checkOutput("aceita", bus.aceita, mAceita);
            checkOutput("concluido", bus.concluido, mPhase == 2);
            checkOutput("navio_atual", bus.navio_atual, mShip);
            checkOutput("posicoes0", bus.posicoes0, mPos[0]);
            checkOutput("posicoes1", bus.posicoes1, mPos[1]);
            checkOutput("posicoes2", bus.posicoes2, mPos[2]);
            checkOutput("posicoes3", bus.posicoes3, mPos[3]);
            checkOutput("posicoes4", bus.posicoes4, mPos[4]);
        end
    end

    task automatic applyStimulus(input logic [6:0] b);
        @(negedge clk);
        bus.iniciar      = b[0];
        bus.btn_cima     = b[1];
        bus.btn_baixo    = b[2];
        bus.btn_esq      = b[3];
        bus.btn_dir      = b[4];
        bus.btn_girar    = b[5];
        bus.btn_confirma = b[6];
        @(negedge clk);
        bus.iniciar      = 1'b0;
        bus.btn_cima     = 1'b0;
        bus.btn_baixo    = 1'b0;
        bus.btn_esq      = 1'b0;
        bus.btn_dir      = 1'b0;
        bus.btn_girar    = 1'b0;
        bus.btn_confirma = 1'b0;
    endtask

    task automatic pressN(input logic [6:0] b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b);
    endtask

    task automatic waitFor(input bit wantAceita, output int l);
        l = -1;
        for (int i = 0; i < 20; i++) begin
            if ((wantAceita ? bus.aceita : bus.rejeita) === 1'b1) begin
                l = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0; bad = 0; cmpEn = 1'b0;
        modelReset();
        reset_n = 1'b0;
        bus.iniciar = 1'b0; bus.btn_cima = 1'b0; bus.btn_baixo = 1'b0; bus.btn_esq = 1'b0;
        bus.btn_dir = 1'b0; bus.btn_girar = 1'b0; bus.btn_confirma = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset posicoes0", bus.posicoes0, 64'd0);
        checkOutput("reset navio_atual", bus.navio_atual, 3'd0);
        checkOutput("reset preview_visivel", bus.preview_visivel, 1'b0);
        checkOutput("reset concluido", bus.concluido, 1'b0);
        reset_n = 1'b1;
        cmpEn   = 1'b1;

        // Ship 0 at (1,1) horizontal.
        applyStimulus(B_INI);
        checkOutput("ship0 preview", bus.posicoes_preview, 64'h9088);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("ship0 aceita latency", lat, 3);
        checkOutput("ship0 posicoes0", bus.posicoes0, 64'h9088);
        checkOutput("ship0 navio_atual", bus.navio_atual, 3'd1);

        // Ship 1 hanging off the right edge.
        pressN(B_RIGHT, 6);
        checkOutput("ship1 edge preview", bus.posicoes_preview, 64'hC0B8);
        applyStimulus(B_OK);
        waitFor(1'b0, lat);
        checkOutput("ship1 oob rejeita latency", lat, 2);
        checkOutput("ship1 posicoes1 empty", bus.posicoes1, 64'd0);

        // Back to (1,1) with saturation, vertical overlap with ship 0.
        pressN(B_LEFT, 7);
        checkOutput("ship1 left saturate", bus.posicoes_preview, 64'h989088);
        applyStimulus(B_ROT);
        applyStimulus(B_OK);
        waitFor(1'b0, lat);
        checkOutput("ship1 overlap rejeita latency", lat, 0);
        pressN(B_RIGHT, 2);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("ship1 aceita latency", lat, 4);
        checkOutput("ship1 posicoes1", bus.posicoes1, 64'h1991898);

        // Ship 2: cancelling vertical pulses, left at X=1, confirm beats move.
        applyStimulus(B_UP | B_DOWN);
        checkOutput("ship2 up+down cancel", bus.posicoes_preview, 64'h989088);
        applyStimulus(B_LEFT);
        checkOutput("ship2 left at x1", bus.posicoes_preview, 64'h989088);
        pressN(B_UP, 3);
        applyStimulus(B_OK | B_RIGHT);
        waitFor(1'b1, lat);
        checkOutput("ship2 aceita latency", lat, 4);
        checkOutput("ship2 posicoes2", bus.posicoes2, 64'h21A1208);

        // Ships 3 and 4 along rows 6 and 8.
        pressN(B_UP, 5);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("ship3 aceita latency", lat, 5);
        pressN(B_UP, 7);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("ship4 aceita latency", lat, 6);
        @(negedge clk);
        checkOutput("done concluido", bus.concluido, 1'b1);
        checkOutput("done navio_atual", bus.navio_atual, 3'd4);
        checkOutput("done cell count", countCells(bus.posicoes0) + countCells(bus.posicoes1)
                    + countCells(bus.posicoes2) + countCells(bus.posicoes3)
                    + countCells(bus.posicoes4), 17);
        checkOutput("model occupancy count", mCount, 17);
        applyStimulus(B_UP | B_OK);
        checkOutput("done ignores buttons", bus.concluido, 1'b1);

        // Restart, then reset in the middle of a check.
        applyStimulus(B_INI);
        checkOutput("restart posicoes0 cleared", bus.posicoes0, 64'd0);
        checkOutput("restart concluido", bus.concluido, 1'b0);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("restart ship0 latency", lat, 3);
        pressN(B_UP, 2);
        applyStimulus(B_OK);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midcheck reset posicoes0", bus.posicoes0, 64'd0);
        checkOutput("midcheck reset visivel", bus.preview_visivel, 1'b0);
        checkOutput("midcheck reset navio_atual", bus.navio_atual, 3'd0);
        checkOutput("midcheck reset preview", bus.posicoes_preview, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(B_OK);
        checkOutput("idle ignores confirm", bus.preview_visivel, 1'b0);
        applyStimulus(B_INI);
        applyStimulus(B_OK);
        waitFor(1'b1, lat);
        checkOutput("post reset ship0 latency", lat, 3);
        checkOutput("post reset posicoes0", bus.posicoes0, 64'h9088);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_posicionamento_frota.md
Name: controle_posicionamento_frota

Overview:
- Sequencer that lets the player place the fleet on the 8x8 map before play.
- Moves a ship anchor from one-cycle button pulses and rotates it. On confirm it checks the candidate cells one per cycle against an occupancy bitmap, then commits the ship's position vector.
- Feeds the per-ship VGA renderers (submarino, cruzador, hidroaviao, encouracado, porta-avioes) and a preview renderer.

Parameters:
- N_NAVIOS, 5, ships placed, in fixed index order 0..4.
- LEN0..LEN4, 2,3,3,4,5, cells per ship; legal range 1..7.
- BLINK_CYCLES, 12_500_000, preview half-period in clocks; used only with BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- iniciar  in  1  start pulse; honoured only in IDLE or DONE.
- btn_cima, btn_baixo, btn_esq, btn_dir  in  1 each  one-cycle move pulses.
- btn_girar  in  1  orientation toggle pulse.
- btn_confirma  in  1  placement confirm pulse.
- posicoes0..posicoes4  out  64 each  committed ship vectors.
- posicoes_preview  out  64  candidate ship vector.
- preview_visivel  out  1  preview enable for the renderer.
- navio_atual  out  3  index of the ship being placed.
- aceita  out  1  one-cycle pulse on commit.
- rejeita  out  1  one-cycle pulse on failed check.
- concluido  out  1  level, high in DONE.

Behaviour:
- Vector format:
  - cell k (0..6) has X at bits [6+8k -:4] and Y at [10+8k -:4].
  - Bits [2:0], bits [63:59] and cells k ≥ LEN are 0.
  - Coordinate 0 means "no cell", and the renderer ignores it.
- Reset state:
  - State IDLE, all output vectors 0, occupancy bitmap 0.
  - Cursor at (1,1), horizontal.
  - aceita=rejeita=concluido=0, navio_atual=0, preview_visivel=0.
- States: IDLE, PLACE, CHECK, COMMIT, DONE.
- IDLE/DONE on iniciar:
  - Clear the occupancy bitmap and posicoes0..4.
  - Cursor to (1,1), horizontal, navio_atual=0.
  - Next state PLACE.
- PLACE moves:
  - Each move pulse moves the anchor by 1, saturating at 1 and 8.
  - Y grows upward (btn_cima increments Y).
  - Opposing pulses in the same cycle cancel on that axis.
  - btn_girar toggles orientation.
  - Effects are visible on posicoes_preview the following cycle.
- Candidate cells:
  - Horizontal: cell k = (cx+k, cy).
  - Vertical: cell k = (cx, cy+k).
  - A cell with coordinate > 8 is out of bounds and is emitted as X=Y=0 in the preview.
- PLACE confirm:
  - btn_confirma goes to CHECK with k=0.
  - Confirm has priority: moves and rotate in the same cycle are ignored.
  - The anchor and orientation are frozen until PLACE is re-entered.
- CHECK:
  - Examines one cell k per cycle: in-bounds and occupancy bit (8*(y-1)+(x-1)) clear.
  - First failure: next state PLACE, rejeita=1 for that one cycle.
  - k=LEN-1 passes: next state COMMIT.
  - Latency from confirm to COMMIT is exactly LEN cycles.
- COMMIT (one cycle):
  - Write posicoesN from the frozen candidate and set its LEN occupancy bits.
  - aceita=1 the next cycle.
  - If navio_atual=N_NAVIOS-1, go to DONE; otherwise increment navio_atual, reset the cursor to (1,1) horizontal, go to PLACE.
- All button inputs are ignored in CHECK, COMMIT, IDLE and DONE; iniciar is excepted in IDLE/DONE.
- preview_visivel is 1 only in PLACE/CHECK; posicoes_preview is 0 elsewhere.
- In DONE, posicoes0..4 hold and concluido=1.
- reset_n asserted mid-CHECK or mid-COMMIT: all state and outputs return to reset values immediately; a partial commit is never visible.

Optional Feature:
- BLINK_EN defined:
  - A counter of width ceil(log2(BLINK_CYCLES)) toggles preview_visivel every BLINK_CYCLES clocks while in PLACE.
  - The counter restarts with preview_visivel=1 on each entry to PLACE and on any anchor move.
- BLINK_EN undefined: no counter is instantiated; preview_visivel follows the PLACE/CHECK rule only.

Decomposition:
- Package frota_pkg:
  - N_NAVIOS, LEN array, COORD_W=4.
  - State enum.
  - Bit-offset constants 6 and 10, stride 8.
  - Occupancy-index function.
- Sub-module calc_celula (combinational):
  - Inputs: anchor, orientation, k.
  - Outputs: cell (x,y) and in-bounds flag.
  - Shared by preview generation and CHECK.

Test Plan:
- Reset, iniciar, then confirm at (1,1) horizontal -> after 2 CHECK cycles aceita; posicoes0 has X=1,Y=1 and X=2,Y=1 at cells 0-1; navio_atual=1.
- Ship 1 moved right 6 times to (7,1), confirm -> cell (9,1) out of bounds; rejeita pulses on CHECK cycle 3 at the latest; posicoes1 stays 0.
- Ship 1 at (1,1) vertical overlapping ship 0 -> rejeita after the first CHECK cycle. Move right 2 to (3,1), confirm -> aceita after 3 CHECK cycles.
- btn_cima and btn_baixo pulsed in the same cycle -> anchor Y unchanged. btn_esq at X=1 -> X stays 1.
- btn_confirma with btn_dir in the same cycle -> candidate uses the pre-move anchor.
- Place all 5 ships legally -> concluido=1 and 17 occupancy bits set. reset_n low during a CHECK -> all posicoes=0 and state IDLE.
